// File: rtl/rs_multi_cdb_pkg.sv
// Shared widths, defaults and decode record for the rs_multi_cdb reservation station.
package rs_multi_cdb_pkg;

    localparam int OPCODE_WID    = 7;
    localparam int FUNCT3_WID    = 3;
    localparam int FUNCT7_WID    = 1;
    localparam int RS_DEPTH_DEF  = 16;
    localparam int CDB_PORTS_DEF = 2;
    localparam int ROB_POS_W_DEF = 4;
    localparam int DATA_W_DEF    = 32;

    typedef struct packed {
        logic [OPCODE_WID-1:0] opcode;
        logic [FUNCT3_WID-1:0] funct3;
        logic [FUNCT7_WID-1:0] funct7;
    } decode_t;

    // The pending flag sits directly above the ROB position bits of a tag.
    function automatic int tag_pend_bit(input int rob_pos_w);
        return rob_pos_w;
    endfunction

endpackage

// File: rtl/rs_multi_cdb_if.sv
// Issue, ALU dispatch and CDB broadcast bundle; the station uses the slave modport.
interface rs_multi_cdb_if
    import rs_multi_cdb_pkg::*;
#(
    parameter int CDB_PORTS = CDB_PORTS_DEF,
    parameter int ROB_POS_W = ROB_POS_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) ();

    logic                           issue;
    logic [ROB_POS_W-1:0]           issue_rob_pos;
    logic [OPCODE_WID-1:0]          issue_opcode;
    logic [FUNCT3_WID-1:0]          issue_funct3;
    logic [FUNCT7_WID-1:0]          issue_funct7;
    logic [DATA_W-1:0]              issue_rs1_val;
    logic [DATA_W-1:0]              issue_rs2_val;
    logic [ROB_POS_W:0]             issue_rs1_tag;
    logic [ROB_POS_W:0]             issue_rs2_tag;
    logic [DATA_W-1:0]              issue_imm;
    logic [DATA_W-1:0]              issue_pc;
    logic                           rs_nxt_full;

    logic                           alu_en;
    logic                           alu_ready;
    logic [OPCODE_WID-1:0]          alu_opcode;
    logic [FUNCT3_WID-1:0]          alu_funct3;
    logic [FUNCT7_WID-1:0]          alu_funct7;
    logic [DATA_W-1:0]              alu_val1;
    logic [DATA_W-1:0]              alu_val2;
    logic [DATA_W-1:0]              alu_imm;
    logic [DATA_W-1:0]              alu_pc;
    logic [ROB_POS_W-1:0]           alu_rob_pos;

    logic [CDB_PORTS-1:0]           cdb_valid;
    logic [CDB_PORTS*ROB_POS_W-1:0] cdb_rob_pos;
    logic [CDB_PORTS*DATA_W-1:0]    cdb_val;

    modport master (
        output issue, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_val, issue_rs2_val, issue_rs1_tag, issue_rs2_tag,
               issue_imm, issue_pc, alu_ready, cdb_valid, cdb_rob_pos, cdb_val,
        input  rs_nxt_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

    modport slave (
        input  issue, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_val, issue_rs2_val, issue_rs1_tag, issue_rs2_tag,
               issue_imm, issue_pc, alu_ready, cdb_valid, cdb_rob_pos, cdb_val,
        output rs_nxt_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

endinterface

// File: rtl/rs_multi_cdb_select.sv
// rs_select: one-of-N picker, either oldest via an age matrix or by fixed index priority.
module rs_select #(
    parameter int N         = 16,
    parameter bit USE_AGE   = 1'b0,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0][N-1:0]  older_i,
    output logic [N-1:0]         onehot_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);

    localparam int IW = $clog2(N);

    logic blocked;

    // older_i[k][i] means k entered before i; a requester is eligible only if no older one requests.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        blocked  = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            if (USE_AGE) begin
                for (int k = 0; k < N; k++) begin
                    if (k != i && req_i[k] && older_i[k][i]) begin
                        blocked = 1'b1;
                    end
                end
            end
            if (req_i[i] && !blocked && (!found_o || !LOW_FIRST)) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IW'(i);
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station for the integer ALU with multi-channel CDB wakeup and ALU back-pressure.
// Define RS_AGE_ORDER_EN for oldest-first dispatch; otherwise the highest-index ready entry goes.
module rs_multi_cdb
    import rs_multi_cdb_pkg::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int CDB_PORTS = CDB_PORTS_DEF,
    parameter int ROB_POS_W = ROB_POS_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rdy_i,
    input  logic          rollback_i,
    rs_multi_cdb_if.slave bus
);

    localparam int IW   = $clog2(RS_DEPTH);
    localparam int TW   = ROB_POS_W + 1;
    localparam int CW   = $clog2(RS_DEPTH + 1);
    localparam int PEND = tag_pend_bit(ROB_POS_W);

    logic [RS_DEPTH-1:0]                 busy_q, busy_d;
    logic [RS_DEPTH-1:0][ROB_POS_W-1:0]  rob_q, rob_d;
    decode_t [RS_DEPTH-1:0]              dec_q, dec_d;
    logic [RS_DEPTH-1:0][TW-1:0]         tag1_q, tag1_d, tag2_q, tag2_d;
    logic [RS_DEPTH-1:0][DATA_W-1:0]     val1_q, val1_d, val2_q, val2_d;
    logic [RS_DEPTH-1:0][DATA_W-1:0]     imm_q, imm_d, pc_q, pc_d;

    logic                 alu_en_q, alu_en_d;
    decode_t              alu_dec_q, alu_dec_d;
    logic [DATA_W-1:0]    alu_val1_q, alu_val1_d, alu_val2_q, alu_val2_d;
    logic [DATA_W-1:0]    alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
    logic [ROB_POS_W-1:0] alu_rob_q, alu_rob_d;
    logic                 full_q, full_d;

    logic [CDB_PORTS-1:0][ROB_POS_W-1:0] cdb_pos;
    logic [CDB_PORTS-1:0][DATA_W-1:0]    cdb_data;

    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] sel_onehot, free_onehot;
    logic [IW-1:0]       sel_idx, free_idx;
    logic                sel_found, free_found;
    logic                fire, issue_acc;
    logic [CW-1:0]       busy_cnt, next_cnt;

    assign cdb_pos  = bus.cdb_rob_pos;
    assign cdb_data = bus.cdb_val;

    // Resolve a pending tag against every valid channel; iterating downwards lets the lowest channel win.
    function automatic logic [TW+DATA_W-1:0] wake(
        input logic [TW-1:0]                      tag,
        input logic [DATA_W-1:0]                  val,
        input logic [CDB_PORTS-1:0]               vld,
        input logic [CDB_PORTS-1:0][ROB_POS_W-1:0] pos,
        input logic [CDB_PORTS-1:0][DATA_W-1:0]    data
    );
        logic [TW-1:0]     t;
        logic [DATA_W-1:0] v;
        t = tag;
        v = val;
        for (int k = CDB_PORTS - 1; k >= 0; k--) begin
            if (vld[k] && tag == {1'b1, pos[k]}) begin
                t       = tag;
                t[PEND] = 1'b0;
                v       = data[k];
            end
        end
        return {t, v};
    endfunction

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            ready[e] = busy_q[e] & ~tag1_q[e][PEND] & ~tag2_q[e][PEND];
        end
    end

    // Free-slot search looks only at registered busy bits, so a slot dispatched this cycle stays taken.
    rs_select #(.N(RS_DEPTH), .USE_AGE(1'b0), .LOW_FIRST(1'b1)) u_free (
        .req_i    (~busy_q),
        .older_i  ('0),
        .onehot_o (free_onehot),
        .idx_o    (free_idx),
        .found_o  (free_found)
    );

`ifdef RS_AGE_ORDER_EN
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;

    // A newcomer is younger than everything already resident and older than nothing.
    always_comb begin
        older_d = older_q;
        if (issue_acc) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                older_d[free_idx][k] = 1'b0;
                older_d[k][free_idx] = busy_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            older_q <= '0;
        end else if (rdy_i && !rollback_i) begin
            older_q <= older_d;
        end
    end

    rs_select #(.N(RS_DEPTH), .USE_AGE(1'b1), .LOW_FIRST(1'b1)) u_pick (
        .req_i    (ready),
        .older_i  (older_q),
        .onehot_o (sel_onehot),
        .idx_o    (sel_idx),
        .found_o  (sel_found)
    );
`else
    rs_select #(.N(RS_DEPTH), .USE_AGE(1'b0), .LOW_FIRST(1'b0)) u_pick (
        .req_i    (ready),
        .older_i  ('0),
        .onehot_o (sel_onehot),
        .idx_o    (sel_idx),
        .found_o  (sel_found)
    );
`endif

    assign fire      = sel_found & (~alu_en_q | bus.alu_ready);
    assign issue_acc = bus.issue & free_found;

    // Entry array update: CDB wakeup, dispatch release, then insertion with same-cycle capture.
    always_comb begin
        busy_d = busy_q;
        rob_d  = rob_q;
        dec_d  = dec_q;
        tag1_d = tag1_q;
        tag2_d = tag2_q;
        val1_d = val1_q;
        val2_d = val2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (busy_q[e]) begin
                {tag1_d[e], val1_d[e]} = wake(tag1_q[e], val1_q[e], bus.cdb_valid, cdb_pos, cdb_data);
                {tag2_d[e], val2_d[e]} = wake(tag2_q[e], val2_q[e], bus.cdb_valid, cdb_pos, cdb_data);
            end
        end
        if (fire) begin
            busy_d = busy_d & ~sel_onehot;
        end
        if (issue_acc) begin
            busy_d          = busy_d | free_onehot;
            rob_d[free_idx] = bus.issue_rob_pos;
            dec_d[free_idx] = {bus.issue_opcode, bus.issue_funct3, bus.issue_funct7};
            imm_d[free_idx] = bus.issue_imm;
            pc_d[free_idx]  = bus.issue_pc;
            {tag1_d[free_idx], val1_d[free_idx]} =
                wake(bus.issue_rs1_tag, bus.issue_rs1_val, bus.cdb_valid, cdb_pos, cdb_data);
            {tag2_d[free_idx], val2_d[free_idx]} =
                wake(bus.issue_rs2_tag, bus.issue_rs2_val, bus.cdb_valid, cdb_pos, cdb_data);
        end
    end

    // Dispatch register holds while the ALU stalls and reloads only when the slot frees up.
    always_comb begin
        alu_en_d   = alu_en_q;
        alu_dec_d  = alu_dec_q;
        alu_val1_d = alu_val1_q;
        alu_val2_d = alu_val2_q;
        alu_imm_d  = alu_imm_q;
        alu_pc_d   = alu_pc_q;
        alu_rob_d  = alu_rob_q;
        if (fire) begin
            alu_en_d   = 1'b1;
            alu_dec_d  = dec_q[sel_idx];
            alu_val1_d = val1_q[sel_idx];
            alu_val2_d = val2_q[sel_idx];
            alu_imm_d  = imm_q[sel_idx];
            alu_pc_d   = pc_q[sel_idx];
            alu_rob_d  = rob_q[sel_idx];
        end else if (bus.alu_ready) begin
            alu_en_d = 1'b0;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            busy_cnt = busy_cnt + CW'(busy_q[e]);
        end
        next_cnt = busy_cnt + CW'(issue_acc) - CW'(fire);
        full_d   = (next_cnt == CW'(RS_DEPTH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            rob_q      <= '0;
            dec_q      <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            val1_q     <= '0;
            val2_q     <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            alu_en_q   <= 1'b0;
            alu_dec_q  <= '0;
            alu_val1_q <= '0;
            alu_val2_q <= '0;
            alu_imm_q  <= '0;
            alu_pc_q   <= '0;
            alu_rob_q  <= '0;
            full_q     <= 1'b0;
        end else if (rollback_i) begin
            busy_q   <= '0;
            alu_en_q <= 1'b0;
            full_q   <= 1'b0;
        end else if (rdy_i) begin
            busy_q     <= busy_d;
            rob_q      <= rob_d;
            dec_q      <= dec_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
            val1_q     <= val1_d;
            val2_q     <= val2_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            alu_en_q   <= alu_en_d;
            alu_dec_q  <= alu_dec_d;
            alu_val1_q <= alu_val1_d;
            alu_val2_q <= alu_val2_d;
            alu_imm_q  <= alu_imm_d;
            alu_pc_q   <= alu_pc_d;
            alu_rob_q  <= alu_rob_d;
            full_q     <= full_d;
        end
    end

    assign bus.rs_nxt_full = full_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_opcode  = alu_dec_q.opcode;
    assign bus.alu_funct3  = alu_dec_q.funct3;
    assign bus.alu_funct7  = alu_dec_q.funct7;
    assign bus.alu_val1    = alu_val1_q;
    assign bus.alu_val2    = alu_val2_q;
    assign bus.alu_imm     = alu_imm_q;
    assign bus.alu_pc      = alu_pc_q;
    assign bus.alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed self-checking bench for rs_multi_cdb; expectations follow RS_AGE_ORDER_EN when defined.
module tb_rs_multi_cdb;

    logic clk;
    logic rst_n;
    logic rdy;
    logic rollback;
    int   errors;
    int   checks;

    rs_multi_cdb_if #(.CDB_PORTS(2), .ROB_POS_W(4), .DATA_W(32)) bus ();

    rs_multi_cdb #(.RS_DEPTH(16), .CDB_PORTS(2), .ROB_POS_W(4), .DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rdy_i      (rdy),
        .rollback_i (rollback),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rob, input logic [4:0] t1, input logic [31:0] v1,
                                 input logic [4:0] t2, input logic [31:0] v2);
        bus.issue         = 1'b1;
        bus.issue_rob_pos = rob;
        bus.issue_opcode  = 7'h33;
        bus.issue_funct3  = rob[2:0];
        bus.issue_funct7  = rob[0];
        bus.issue_rs1_tag = t1;
        bus.issue_rs1_val = v1;
        bus.issue_rs2_tag = t2;
        bus.issue_rs2_val = v2;
        bus.issue_imm     = 32'h100 + {28'h0, rob};
        bus.issue_pc      = 32'h1000 + {26'h0, rob, 2'b00};
    endtask

    task automatic idle();
        bus.issue = 1'b0;
    endtask

    task automatic broadcast(input int ch, input logic [3:0] pos, input logic [31:0] val);
        bus.cdb_valid[ch]          = 1'b1;
        bus.cdb_rob_pos[ch*4 +: 4] = pos;
        bus.cdb_val[ch*32 +: 32]   = val;
    endtask

    task automatic clearCdb();
        bus.cdb_valid = '0;
    endtask

    initial begin
        logic [3:0] r;
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        rdy      = 1'b1;
        rollback = 1'b0;
        bus.issue = 1'b0;
        bus.issue_rob_pos = '0;
        bus.issue_opcode = '0;
        bus.issue_funct3 = '0;
        bus.issue_funct7 = '0;
        bus.issue_rs1_tag = '0;
        bus.issue_rs2_tag = '0;
        bus.issue_rs1_val = '0;
        bus.issue_rs2_val = '0;
        bus.issue_imm = '0;
        bus.issue_pc = '0;
        bus.alu_ready = 1'b1;
        bus.cdb_valid = '0;
        bus.cdb_rob_pos = '0;
        bus.cdb_val = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_alu_en", bus.alu_en, 0);
        checkOutput("reset_full", bus.rs_nxt_full, 0);
        checkOutput("reset_val1", bus.alu_val1, 0);
        #2 rst_n = 1'b1;

        // Ready-at-issue: one cycle to land in the array, dispatch on the next edge
        applyStimulus(4'd1, 5'h00, 32'h11, 5'h00, 32'h22);
        tick();
        idle();
        checkOutput("t1_not_yet", bus.alu_en, 0);
        tick();
        checkOutput("t1_en", bus.alu_en, 1);
        checkOutput("t1_rob", bus.alu_rob_pos, 4'd1);
        checkOutput("t1_val1", bus.alu_val1, 32'h11);
        checkOutput("t1_val2", bus.alu_val2, 32'h22);
        checkOutput("t1_imm", bus.alu_imm, 32'h101);
        checkOutput("t1_pc", bus.alu_pc, 32'h1004);
        checkOutput("t1_funct3", bus.alu_funct3, 3'd1);
        tick();
        checkOutput("t1_drain", bus.alu_en, 0);

        // Operand broadcast in the very cycle of issue
        applyStimulus(4'd4, 5'h13, 32'h0, 5'h00, 32'h5);
        broadcast(1, 4'd3, 32'hDEAD_BEEF);
        tick();
        idle();
        clearCdb();
        checkOutput("t2_not_yet", bus.alu_en, 0);
        tick();
        checkOutput("t2_en", bus.alu_en, 1);
        checkOutput("t2_val1", bus.alu_val1, 32'hDEAD_BEEF);
        checkOutput("t2_val2", bus.alu_val2, 32'h5);
        checkOutput("t2_rob", bus.alu_rob_pos, 4'd4);
        tick();
        checkOutput("t2_drain", bus.alu_en, 0);

        // Two channels wake both operands of one entry
        applyStimulus(4'd5, 5'h16, 32'h0, 5'h17, 32'h0);
        tick();
        idle();
        broadcast(0, 4'd6, 32'hAAAA_0006);
        broadcast(1, 4'd7, 32'hBBBB_0007);
        tick();
        clearCdb();
        checkOutput("t3_wake_latency", bus.alu_en, 0);
        tick();
        checkOutput("t3_en", bus.alu_en, 1);
        checkOutput("t3_val1", bus.alu_val1, 32'hAAAA_0006);
        checkOutput("t3_val2", bus.alu_val2, 32'hBBBB_0007);
        tick();
        checkOutput("t3_drain", bus.alu_en, 0);

        // Pending rob 7 then ready rob 2: rob 2 leaves first, rob 7 after its wakeup
        applyStimulus(4'd7, 5'h19, 32'h0, 5'h00, 32'h70);
        tick();
        applyStimulus(4'd2, 5'h00, 32'h20, 5'h00, 32'h21);
        tick();
        idle();
        broadcast(0, 4'd9, 32'h9999);
        tick();
        clearCdb();
        checkOutput("t4_first_rob", bus.alu_rob_pos, 4'd2);
        checkOutput("t4_first_en", bus.alu_en, 1);
        tick();
        checkOutput("t4_second_rob", bus.alu_rob_pos, 4'd7);
        checkOutput("t4_second_val1", bus.alu_val1, 32'h9999);
        tick();
        checkOutput("t4_drain", bus.alu_en, 0);

        // Back-pressure: held output while two ready entries queue in slots 0 (older) and 1
        bus.alu_ready = 1'b0;
        applyStimulus(4'd10, 5'h00, 32'hF0, 5'h00, 32'hF1);
        tick();
        idle();
        tick();
        checkOutput("bp_load_en", bus.alu_en, 1);
        checkOutput("bp_load_rob", bus.alu_rob_pos, 4'd10);
        applyStimulus(4'd3, 5'h00, 32'h30, 5'h00, 32'h31);
        tick();
        applyStimulus(4'd12, 5'h00, 32'hC0, 5'h00, 32'hC1);
        tick();
        idle();
        checkOutput("bp_hold_rob_a", bus.alu_rob_pos, 4'd10);
        tick();
        checkOutput("bp_hold_rob_b", bus.alu_rob_pos, 4'd10);
        checkOutput("bp_hold_val1", bus.alu_val1, 32'hF0);
        tick();
        checkOutput("bp_hold_en", bus.alu_en, 1);
        checkOutput("bp_hold_val2", bus.alu_val2, 32'hF1);
        bus.alu_ready = 1'b1;
        tick();
`ifdef RS_AGE_ORDER_EN
        checkOutput("order_first", bus.alu_rob_pos, 4'd3);
        tick();
        checkOutput("order_second", bus.alu_rob_pos, 4'd12);
`else
        checkOutput("order_first", bus.alu_rob_pos, 4'd12);
        tick();
        checkOutput("order_second", bus.alu_rob_pos, 4'd3);
`endif
        checkOutput("order_second_en", bus.alu_en, 1);
        tick();
        checkOutput("order_drain", bus.alu_en, 0);

        // Global enable low: an issue presented while frozen leaves no trace
        rdy = 1'b0;
        applyStimulus(4'd8, 5'h00, 32'h80, 5'h00, 32'h81);
        tick();
        tick();
        checkOutput("freeze_en", bus.alu_en, 0);
        idle();
        rdy = 1'b1;
        tick();
        tick();
        checkOutput("freeze_no_entry", bus.alu_en, 0);

        // Fill all 16 slots with pending entries, slot i waiting on rob position i
        for (int i = 0; i < 15; i++) begin
            r = 4'(i);
            applyStimulus(r, {1'b1, r}, 32'h0, 5'h00, {28'h0, r});
            tick();
        end
        checkOutput("full_at_15", bus.rs_nxt_full, 0);
        applyStimulus(4'd15, 5'h1F, 32'h0, 5'h00, 32'hF);
        tick();
        checkOutput("full_at_16", bus.rs_nxt_full, 1);
        applyStimulus(4'd13, 5'h00, 32'h77, 5'h00, 32'h78);
        tick();
        idle();
        checkOutput("full_17th_full", bus.rs_nxt_full, 1);
        checkOutput("full_17th_no_dispatch", bus.alu_en, 0);
        broadcast(0, 4'd5, 32'h55);
        tick();
        clearCdb();
        checkOutput("full_after_wake", bus.rs_nxt_full, 1);
        tick();
        checkOutput("full_dispatch_en", bus.alu_en, 1);
        checkOutput("full_dispatch_rob", bus.alu_rob_pos, 4'd5);
        checkOutput("full_dispatch_val1", bus.alu_val1, 32'h55);
        checkOutput("full_cleared", bus.rs_nxt_full, 0);

        // Rollback with a concurrent ready issue and broadcast empties everything
        rollback = 1'b1;
        applyStimulus(4'd1, 5'h00, 32'h1234, 5'h00, 32'h0);
        broadcast(0, 4'd6, 32'h66);
        tick();
        rollback = 1'b0;
        idle();
        clearCdb();
        checkOutput("rb_en", bus.alu_en, 0);
        checkOutput("rb_full", bus.rs_nxt_full, 0);
        broadcast(0, 4'd0, 32'h0);
        broadcast(1, 4'd1, 32'h0);
        tick();
        clearCdb();
        tick();
        checkOutput("rb_empty_a", bus.alu_en, 0);
        tick();
        checkOutput("rb_empty_b", bus.alu_en, 0);

        // Asynchronous reset with three resident entries and a held dispatch
        bus.alu_ready = 1'b0;
        applyStimulus(4'd1, 5'h00, 32'h1, 5'h00, 32'h0);
        tick();
        applyStimulus(4'd2, 5'h00, 32'h2, 5'h00, 32'h0);
        tick();
        applyStimulus(4'd3, 5'h00, 32'h3, 5'h00, 32'h0);
        tick();
        applyStimulus(4'd4, 5'h00, 32'h4, 5'h00, 32'h0);
        tick();
        idle();
        checkOutput("mid_pre_en", bus.alu_en, 1);
        checkOutput("mid_pre_rob", bus.alu_rob_pos, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_en", bus.alu_en, 0);
        checkOutput("mid_rst_full", bus.rs_nxt_full, 0);
        checkOutput("mid_rst_rob", bus.alu_rob_pos, 4'd0);
        #10 rst_n = 1'b1;
        bus.alu_ready = 1'b1;
        tick();
        checkOutput("mid_post_a", bus.alu_en, 0);
        tick();
        tick();
        checkOutput("mid_post_b", bus.alu_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
